// File: rtl/exec_unit_dtypes.sv
// Shared exec-unit datatypes: addresses, operands, iqueue entries, cache /
// interconnect / ALPU channel structs and the operand collector FSM state.
// No logic; imported by the operand collector and its instruction FIFO.
package exec_unit_dtypes;

  localparam int DATA_W            = 16;
  localparam int LOG2_NUM_REG      = 4;
  localparam int LOG2_NUM_EU       = 2;
  // Immediate field spans the whole address body so both views of an operand are the same width.
  localparam int IMM_W             = 1 + LOG2_NUM_EU + LOG2_NUM_REG;
  localparam int IQUEUE_DEPTH      = 4;
  localparam int LOG2_IQUEUE_DEPTH = $clog2(IQUEUE_DEPTH);

  typedef struct packed {
    logic [LOG2_NUM_EU-1:0]  eu_idx;
    logic [LOG2_NUM_REG-1:0] reg_idx;
  } type_exec_unit_addr;

  typedef struct packed {
    logic                    is_output;
    logic [LOG2_NUM_EU-1:0]  eu_idx;
    logic [LOG2_NUM_REG-1:0] reg_idx;
  } type_operand_addr;

  typedef struct packed {
    logic [IMM_W-1:0] data;
  } type_operand_imm;

  typedef union packed {
    type_operand_imm  as_immediate;
    type_operand_addr as_addr;
  } type_operand_body;

  // opNm = 0: immediate, opNm = 1: register address (local or foreign).
  typedef struct packed {
    logic             opNm;
    type_operand_body body;
  } type_operand;

  typedef struct packed {
    type_operand        op0;
    type_operand        op1;
    type_exec_unit_addr opd;
  } type_iqueue_entry;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } type_ycache_data;

  typedef struct packed {
    logic               valid;
    type_exec_unit_addr addr;
    logic [DATA_W-1:0]  data;
  } type_icon_channel;

  typedef struct packed {
    logic ready;
  } type_icon_rx_channel;

  typedef struct packed {
    logic [DATA_W-1:0] op0_data;
    logic              op0_valid;
    logic [DATA_W-1:0] op1_data;
    logic              op1_valid;
    logic              opd_ready;
  } type_alpu_channel_rx;

  typedef enum logic [2:0] {
    OC_IDLE    = 3'd0,
    OC_OPERAND = 3'd1,
    OC_LWAIT   = 3'd2,
    OC_FWAIT   = 3'd3,
    OC_PRESENT = 3'd4
  } type_opcollect_state;

  function automatic type_exec_unit_addr opnd_addr(input type_operand op);
    type_exec_unit_addr a;
    a.eu_idx  = op.body.as_addr.eu_idx;
    a.reg_idx = op.body.as_addr.reg_idx;
    return a;
  endfunction

  function automatic logic [DATA_W-1:0] opnd_imm(input type_operand op);
    return DATA_W'(op.body.as_immediate.data);
  endfunction

endpackage

// File: rtl/eu_operand_collector_fifo.sv
// Purpose: instruction queue FIFO (eu_iqueue_fifo) for the operand collector.
// Latency: push visible at the head one cycle later; head read is combinational (no bypass).
// Backpressure: o_full from the registered count; a push while full is dropped even if a pop
//   happens in the same cycle; a pop while empty is ignored.
// Ports: i_clk, reset (sync, active-high), i_push/i_push_data, i_pop/o_pop_data, o_full, o_empty.
module eu_iqueue_fifo
  import exec_unit_dtypes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_push,
  input  type_iqueue_entry i_push_data,
  input  logic             i_pop,
  output type_iqueue_entry o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  type_iqueue_entry r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/eu_operand_collector.sv
// Purpose: buffers dispatched instructions and resolves both operands (immediate, local ycache
//   read, or foreign interconnect fetch) before presenting them to the ALPU.
// Latency: push to presentation 4 cycles for imm/imm; +1 per local operand; +1 plus
//   request/response wait per foreign operand.
// Backpressure: o_instr_ready drops when the queue is full; presented operands are held until
//   i_alpu_accept; foreign request held until accepted; non-matching responses are not taken.
// Ports: i_clk, reset, i_instr/_valid/o_instr_ready, o_lc_rd_en/idx, i_lc_rd_data,
//   o_icon_req/i_icon_req_rx, i_icon_resp/o_icon_resp_rx, o_alpu, o_alpu_opd, i_opd_ready,
//   i_alpu_accept; o_stall_cnt only when EU_OPCOLLECT_PERF_EN is defined.
module eu_operand_collector
  import exec_unit_dtypes::*;
#(
  parameter int IQUEUE_DEPTH = 4,
  parameter int EU_IDX       = 0
) (
  input  logic                    i_clk,
  input  logic                    reset,
  input  type_iqueue_entry        i_instr,
  input  logic                    i_instr_valid,
  output logic                    o_instr_ready,
  output logic                    o_lc_rd_en,
  output logic [LOG2_NUM_REG-1:0] o_lc_rd_idx,
  input  type_ycache_data         i_lc_rd_data,
  output type_icon_channel        o_icon_req,
  input  type_icon_rx_channel     i_icon_req_rx,
  input  type_icon_channel        i_icon_resp,
  output type_icon_rx_channel     o_icon_resp_rx,
  output type_alpu_channel_rx     o_alpu,
  output type_exec_unit_addr      o_alpu_opd,
  input  logic                    i_opd_ready,
`ifdef EU_OPCOLLECT_PERF_EN
  input  logic                    i_alpu_accept,
  output logic [31:0]             o_stall_cnt
`else
  input  logic                    i_alpu_accept
`endif
);

  type_opcollect_state r_state;
  type_opcollect_state w_next_state;
  logic                r_sel;
  type_iqueue_entry    r_head;
  logic [DATA_W-1:0]   r_op0_data;
  logic [DATA_W-1:0]   r_op1_data;

  type_iqueue_entry    w_fifo_data;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;

  type_operand         w_cur_op;
  type_exec_unit_addr  w_cur_addr;
  logic                w_is_imm;
  logic                w_is_local;
  logic                w_is_foreign;
  logic                w_resp_hs;
  logic                w_advance;
  logic                w_capture;
  logic [DATA_W-1:0]   w_cap_data;

  eu_iqueue_fifo #(.DEPTH(IQUEUE_DEPTH)) u_iqueue (
    .i_clk       (i_clk),
    .reset       (reset),
    .i_push      (i_instr_valid),
    .i_push_data (i_instr),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign o_instr_ready = !w_full;
  assign w_pop         = (r_state == OC_IDLE) && !w_empty;

  // Operand currently being resolved; the is_output bit plays no part in source decode.
  assign w_cur_op     = r_sel ? r_head.op1 : r_head.op0;
  assign w_cur_addr   = opnd_addr(w_cur_op);
  assign w_is_imm     = !w_cur_op.opNm;
  assign w_is_local   = w_cur_op.opNm && (w_cur_addr.eu_idx == LOG2_NUM_EU'(EU_IDX));
  assign w_is_foreign = w_cur_op.opNm && !w_is_local;

  assign o_lc_rd_en  = (r_state == OC_OPERAND) && w_is_local;
  assign o_lc_rd_idx = w_cur_addr.reg_idx;

  // Request fields derive only from the head registers, so they stay stable while stalled.
  always_comb begin
    o_icon_req       = '0;
    o_icon_req.valid = (r_state == OC_OPERAND) && w_is_foreign;
    o_icon_req.addr  = w_cur_addr;
  end

  // Only the response for our outstanding address is taken; anything else is left stalled.
  assign w_resp_hs = (r_state == OC_FWAIT) && i_icon_resp.valid && (i_icon_resp.addr == w_cur_addr);
  always_comb begin
    o_icon_resp_rx       = '0;
    o_icon_resp_rx.ready = w_resp_hs;
  end

  always_comb begin
    o_alpu           = '0;
    o_alpu.op0_data  = r_op0_data;
    o_alpu.op1_data  = r_op1_data;
    o_alpu.op0_valid = (r_state == OC_PRESENT);
    o_alpu.op1_valid = (r_state == OC_PRESENT);
    o_alpu.opd_ready = i_opd_ready;
  end
  assign o_alpu_opd = r_head.opd;

  // Advance is folded into the capturing cycle: op0 done -> back to OPERAND for op1,
  // op1 done -> PRESENT.
  always_comb begin
    w_next_state = r_state;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    w_cap_data   = '0;
    case (r_state)
      OC_IDLE: begin
        if (!w_empty) w_next_state = OC_OPERAND;
      end
      OC_OPERAND: begin
        if (w_is_imm) begin
          w_capture  = 1'b1;
          w_cap_data = opnd_imm(w_cur_op);
          w_advance  = 1'b1;
        end else if (w_is_local) begin
          w_next_state = OC_LWAIT;
        end else if (i_icon_req_rx.ready) begin
          w_next_state = OC_FWAIT;
        end
      end
      OC_LWAIT: begin
        w_capture  = 1'b1;
        w_cap_data = i_lc_rd_data.data;
        w_advance  = 1'b1;
      end
      OC_FWAIT: begin
        if (w_resp_hs) begin
          w_capture  = 1'b1;
          w_cap_data = i_icon_resp.data;
          w_advance  = 1'b1;
        end
      end
      OC_PRESENT: begin
        if (i_alpu_accept) w_next_state = OC_IDLE;
      end
      default: w_next_state = OC_IDLE;
    endcase
    if (w_advance) w_next_state = r_sel ? OC_PRESENT : OC_OPERAND;
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state    <= OC_IDLE;
      r_sel      <= 1'b0;
      r_head     <= '0;
      r_op0_data <= '0;
      r_op1_data <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_pop) begin
        r_head <= w_fifo_data;
        r_sel  <= 1'b0;
      end else if (w_advance && !r_sel) begin
        r_sel <= 1'b1;
      end
      if (w_capture) begin
        if (r_sel) r_op1_data <= w_cap_data;
        else       r_op0_data <= w_cap_data;
      end
    end
  end

`ifdef EU_OPCOLLECT_PERF_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (r_state == OC_FWAIT) ||
                   ((r_state == OC_OPERAND) && w_is_foreign && !i_icon_req_rx.ready);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_eu_operand_collector.sv
// Self-checking bench for eu_operand_collector: scoreboard of expected operand pairs pushed at
// dispatch and compared when the collector presents to the ALPU; one task per scenario.
module tb_eu_operand_collector;
  import exec_unit_dtypes::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DATA_W-1:0]  d0;
    logic [DATA_W-1:0]  d1;
    type_exec_unit_addr opd;
  } exp_t;

  logic                    clk;
  logic                    reset;
  type_iqueue_entry        instr;
  logic                    instr_valid;
  logic                    instr_ready;
  logic                    lc_rd_en;
  logic [LOG2_NUM_REG-1:0] lc_rd_idx;
  type_ycache_data         lc_rd_data;
  type_icon_channel        icon_req;
  type_icon_rx_channel     icon_req_rx;
  type_icon_channel        icon_resp;
  type_icon_rx_channel     icon_resp_rx;
  type_alpu_channel_rx     alpu;
  type_exec_unit_addr      alpu_opd;
  logic                    opd_ready;
  logic                    alpu_accept;
`ifdef EU_OPCOLLECT_PERF_EN
  logic [31:0]             stall_cnt;
`endif

  logic [DATA_W-1:0] cache [16];
  exp_t              sb [$];
  int                n_cmp;
  int                n_err;

  eu_operand_collector #(.IQUEUE_DEPTH(DEPTH), .EU_IDX(0)) dut (
    .i_clk          (clk),
    .reset          (reset),
    .i_instr        (instr),
    .i_instr_valid  (instr_valid),
    .o_instr_ready  (instr_ready),
    .o_lc_rd_en     (lc_rd_en),
    .o_lc_rd_idx    (lc_rd_idx),
    .i_lc_rd_data   (lc_rd_data),
    .o_icon_req     (icon_req),
    .i_icon_req_rx  (icon_req_rx),
    .i_icon_resp    (icon_resp),
    .o_icon_resp_rx (icon_resp_rx),
    .o_alpu         (alpu),
    .o_alpu_opd     (alpu_opd),
    .i_opd_ready    (opd_ready),
`ifdef EU_OPCOLLECT_PERF_EN
    .i_alpu_accept  (alpu_accept),
    .o_stall_cnt    (stall_cnt)
`else
    .i_alpu_accept  (alpu_accept)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Local ycache model: fixed one-cycle read latency.
  always @(posedge clk) begin
    if (lc_rd_en) lc_rd_data.data <= cache[lc_rd_idx];
  end

  function automatic type_operand mk_imm(input logic [IMM_W-1:0] v);
    type_operand o;
    o = '0;
    o.opNm = 1'b0;
    o.body.as_immediate.data = v;
    return o;
  endfunction

  function automatic type_operand mk_reg(input logic [1:0] eu, input logic [3:0] r, input logic is_out);
    type_operand o;
    o = '0;
    o.opNm = 1'b1;
    o.body.as_addr.is_output = is_out;
    o.body.as_addr.eu_idx = eu;
    o.body.as_addr.reg_idx = r;
    return o;
  endfunction

  function automatic type_iqueue_entry mk_entry(input type_operand a, input type_operand b,
                                                input logic [1:0] eu, input logic [3:0] r);
    type_iqueue_entry e;
    e.op0 = a;
    e.op1 = b;
    e.opd.eu_idx = eu;
    e.opd.reg_idx = r;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_instr_ready: got %b want 1", instr_ready); end
    n_cmp++; if (alpu.op0_valid !== 1'b0 || alpu.op1_valid !== 1'b0) begin n_err++; $display("FAIL reset_valids: got %b%b want 00", alpu.op0_valid, alpu.op1_valid); end
    n_cmp++; if (lc_rd_en !== 1'b0 || icon_req.valid !== 1'b0 || icon_resp_rx.ready !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got lc=%b req=%b rsp=%b want 000", lc_rd_en, icon_req.valid, icon_resp_rx.ready); end
    n_cmp++; if (alpu.op0_data !== 16'h0 || alpu.op1_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", alpu.op0_data, alpu.op1_data); end
`ifdef EU_OPCOLLECT_PERF_EN
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_imm();
    exp_t e;
    @(negedge clk);
    instr = mk_entry(mk_imm(7'h5), mk_imm(7'h9), 2'd0, 4'd7);
    instr_valid = 1'b1;
    sb.push_back({16'h0005, 16'h0009, 2'd0, 4'd7});
    @(negedge clk);
    instr_valid = 1'b0;
    // Cycles 1..3 after the push edge must not yet present; cycle 4 must.
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      n_cmp++;
      if (alpu.op0_valid !== (k == 4) || alpu.op1_valid !== (k == 4)) begin
        n_err++; $display("FAIL imm_latency[%0d]: got %b%b want %b", k, alpu.op0_valid, alpu.op1_valid, (k == 4));
      end
    end
    e = sb.pop_front();
    n_cmp++; if (alpu.op0_data !== e.d0 || alpu.op1_data !== e.d1) begin n_err++; $display("FAIL imm_data: got %h/%h want %h/%h", alpu.op0_data, alpu.op1_data, e.d0, e.d1); end
    n_cmp++; if (alpu_opd !== e.opd) begin n_err++; $display("FAIL imm_opd: got %h want %h", alpu_opd, e.opd); end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      n_cmp++;
      if (alpu.op0_valid !== 1'b1 || alpu.op0_data !== e.d0 || alpu.op1_data !== e.d1 || alpu_opd !== e.opd) begin
        n_err++; $display("FAIL imm_hold[%0d]: got v=%b %h/%h want v=1 %h/%h", h, alpu.op0_valid, alpu.op0_data, alpu.op1_data, e.d0, e.d1);
      end
    end
    opd_ready = 1'b1; #1;
    n_cmp++; if (alpu.opd_ready !== 1'b1) begin n_err++; $display("FAIL opd_ready_hi: got %b want 1", alpu.opd_ready); end
    opd_ready = 1'b0; #1;
    n_cmp++; if (alpu.opd_ready !== 1'b0) begin n_err++; $display("FAIL opd_ready_lo: got %b want 0", alpu.opd_ready); end
    alpu_accept = 1'b1;
    @(negedge clk);
    alpu_accept = 1'b0;
    n_cmp++; if (alpu.op0_valid !== 1'b0) begin n_err++; $display("FAIL imm_accept: got valid %b want 0", alpu.op0_valid); end
  endtask

  task automatic test_local();
    exp_t e;
    int k;
    @(negedge clk);
    instr = mk_entry(mk_reg(2'd0, 4'd3, 1'b0), mk_imm(7'h1), 2'd0, 4'd2);
    instr_valid = 1'b1;
    sb.push_back({16'h00AA, 16'h0001, 2'd0, 4'd2});
    @(negedge clk);
    instr_valid = 1'b0;
    k = 1;
    while (!lc_rd_en && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (lc_rd_en !== 1'b1 || k != 2) begin n_err++; $display("FAIL local_rd_en: got en=%b at cycle %0d want 1 at 2", lc_rd_en, k); end
    n_cmp++; if (lc_rd_idx !== 4'd3) begin n_err++; $display("FAIL local_rd_idx: got %0d want 3", lc_rd_idx); end
    while (!alpu.op0_valid && k < 20) begin @(negedge clk); k++; end
    n_cmp++; if (alpu.op0_valid !== 1'b1 || k != 5) begin n_err++; $display("FAIL local_latency: got valid=%b at cycle %0d want 1 at 5", alpu.op0_valid, k); end
    e = sb.pop_front();
    n_cmp++; if (alpu.op0_data !== e.d0 || alpu.op1_data !== e.d1 || alpu_opd !== e.opd) begin n_err++; $display("FAIL local_data: got %h/%h want %h/%h", alpu.op0_data, alpu.op1_data, e.d0, e.d1); end
    alpu_accept = 1'b1;
    @(negedge clk);
    alpu_accept = 1'b0;
  endtask

  task automatic test_foreign();
    exp_t e;
    int k;
    icon_req_rx.ready = 1'b0;
    @(negedge clk);
    // op1 is local with is_output set: must still decode as a local read.
    instr = mk_entry(mk_reg(2'd1, 4'd2, 1'b0), mk_reg(2'd0, 4'd4, 1'b1), 2'd1, 4'd9);
    instr_valid = 1'b1;
    sb.push_back({16'h0033, 16'h1004, 2'd1, 4'd9});
    @(negedge clk);
    instr_valid = 1'b0;
    k = 0;
    while (!icon_req.valid && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (icon_req.valid !== 1'b1 || icon_req.addr !== {2'd1, 4'd2} || icon_req.data !== 16'h0) begin n_err++; $display("FAIL fgn_req: got v=%b addr=%h data=%h want 1/12/0", icon_req.valid, icon_req.addr, icon_req.data); end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      n_cmp++;
      if (icon_req.valid !== 1'b1 || icon_req.addr !== {2'd1, 4'd2}) begin n_err++; $display("FAIL fgn_req_hold[%0d]: got v=%b addr=%h want 1/12", h, icon_req.valid, icon_req.addr); end
    end
    icon_req_rx.ready = 1'b1;
    @(negedge clk);
    icon_req_rx.ready = 1'b0;
    icon_resp.valid = 1'b1;
    icon_resp.addr = {2'd1, 4'd3};
    icon_resp.data = 16'h0077;
    #1;
    n_cmp++; if (icon_resp_rx.ready !== 1'b0) begin n_err++; $display("FAIL fgn_nomatch_rdy: got %b want 0", icon_resp_rx.ready); end
    @(negedge clk);
    n_cmp++; if (icon_resp_rx.ready !== 1'b0 || alpu.op0_valid !== 1'b0) begin n_err++; $display("FAIL fgn_nomatch_stall: got rdy=%b valid=%b want 0/0", icon_resp_rx.ready, alpu.op0_valid); end
    icon_resp.addr = {2'd1, 4'd2};
    icon_resp.data = 16'h0033;
    #1;
    n_cmp++; if (icon_resp_rx.ready !== 1'b1) begin n_err++; $display("FAIL fgn_match_rdy: got %b want 1", icon_resp_rx.ready); end
    @(negedge clk);
    icon_resp = '0;
    k = 0;
    while (!alpu.op0_valid && k < 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (alpu.op0_valid !== 1'b1) begin
      n_err++; $display("FAIL fgn_present: got valid %b want 1", alpu.op0_valid);
    end else begin
      e = sb.pop_front();
      if (alpu.op0_data !== e.d0 || alpu.op1_data !== e.d1 || alpu_opd !== e.opd) begin n_err++; $display("FAIL fgn_data: got %h/%h want %h/%h", alpu.op0_data, alpu.op1_data, e.d0, e.d1); end
    end
    alpu_accept = 1'b1;
    @(negedge clk);
    alpu_accept = 1'b0;
  endtask

  task automatic test_fifo_full();
    exp_t e;
    int k;
    type_iqueue_entry ent [DEPTH+1];
    for (int i = 0; i <= DEPTH; i++)
      ent[i] = mk_entry(mk_imm(7'(8'h10 + i)), mk_imm(7'(8'h20 + i)), 2'd2, 4'(i));
    // Park one instruction in PRESENT so the queue itself fills.
    @(negedge clk);
    instr = mk_entry(mk_imm(7'h1), mk_imm(7'h2), 2'd3, 4'd1);
    instr_valid = 1'b1;
    sb.push_back({16'h0001, 16'h0002, 2'd3, 4'd1});
    @(negedge clk);
    instr_valid = 1'b0;
    k = 0;
    while (!alpu.op0_valid && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i <= DEPTH; i++) begin
      instr = ent[i];
      instr_valid = 1'b1;
      n_cmp++;
      if (instr_ready !== (i < DEPTH)) begin n_err++; $display("FAIL fifo_ready[%0d]: got %b want %b", i, instr_ready, (i < DEPTH)); end
      if (instr_ready) sb.push_back({16'h0010 + 16'(i), 16'h0020 + 16'(i), 2'd2, 4'(i)});
      @(negedge clk);
    end
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL fifo_refused: got ready %b want 0", instr_ready); end
    instr_valid = 1'b0;
    for (int j = 0; j < DEPTH + 2; j++) begin
      if (j == 1) begin
        // Retry the refused entry now that a slot is draining.
        instr = ent[DEPTH];
        instr_valid = 1'b1;
        k = 0;
        while (!instr_ready && k < 10) begin @(negedge clk); k++; end
        sb.push_back({16'h0010 + 16'(DEPTH), 16'h0020 + 16'(DEPTH), 2'd2, 4'(DEPTH)});
        @(negedge clk);
        instr_valid = 1'b0;
      end
      k = 0;
      while (!alpu.op0_valid && k < 30) begin @(negedge clk); k++; end
      n_cmp++;
      if (alpu.op0_valid !== 1'b1 || sb.size() == 0) begin
        n_err++; $display("FAIL fifo_drain[%0d]: got valid %b want 1", j, alpu.op0_valid);
      end else begin
        e = sb.pop_front();
        if (alpu.op0_data !== e.d0 || alpu.op1_data !== e.d1 || alpu_opd !== e.opd) begin
          n_err++; $display("FAIL fifo_order[%0d]: got %h/%h/%h want %h/%h/%h", j, alpu.op0_data, alpu.op1_data, alpu_opd, e.d0, e.d1, e.opd);
        end
      end
      alpu_accept = 1'b1;
      @(negedge clk);
      alpu_accept = 1'b0;
    end
  endtask

  task automatic test_reset_fwait();
    int k;
    icon_req_rx.ready = 1'b1;
    @(negedge clk);
    instr = mk_entry(mk_reg(2'd2, 4'd5, 1'b0), mk_imm(7'h1), 2'd0, 4'd0);
    instr_valid = 1'b1;
    @(negedge clk);
    instr = mk_entry(mk_reg(2'd1, 4'd6, 1'b0), mk_imm(7'h2), 2'd0, 4'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    k = 0;
    while (!icon_req.valid && k < 10) begin @(negedge clk); k++; end
    @(negedge clk);
    icon_req_rx.ready = 1'b0;
    n_cmp++; if (icon_req.valid !== 1'b0 || alpu.op0_valid !== 1'b0) begin n_err++; $display("FAIL rstf_in_fwait: got req=%b valid=%b want 0/0", icon_req.valid, alpu.op0_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (alpu.op0_valid !== 1'b0 || alpu.op1_valid !== 1'b0 || icon_resp_rx.ready !== 1'b0 || lc_rd_en !== 1'b0) begin n_err++; $display("FAIL rstf_valids: got %b%b%b%b want 0000", alpu.op0_valid, alpu.op1_valid, icon_resp_rx.ready, lc_rd_en); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rstf_ready: got %b want 1", instr_ready); end
    // A surviving queued entry would pop and raise a foreign request here.
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      n_cmp++;
      if (icon_req.valid !== 1'b0 || alpu.op0_valid !== 1'b0) begin n_err++; $display("FAIL rstf_empty[%0d]: got req=%b valid=%b want 0/0", h, icon_req.valid, alpu.op0_valid); end
    end
  endtask

`ifdef EU_OPCOLLECT_PERF_EN
  task automatic test_perf();
    exp_t e;
    int k;
    icon_req_rx.ready = 1'b0;
    @(negedge clk);
    instr = mk_entry(mk_reg(2'd3, 4'd9, 1'b0), mk_imm(7'h3), 2'd1, 4'd1);
    instr_valid = 1'b1;
    sb.push_back({16'h005A, 16'h0003, 2'd1, 4'd1});
    @(negedge clk);
    instr_valid = 1'b0;
    k = 0;
    while (!icon_req.valid && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL perf_start: got %0d want 0", stall_cnt); end
    repeat (7) @(negedge clk);
    n_cmp++; if (stall_cnt !== 32'd7) begin n_err++; $display("FAIL perf_7: got %0d want 7", stall_cnt); end
    icon_req_rx.ready = 1'b1;
    @(negedge clk);
    icon_req_rx.ready = 1'b0;
    n_cmp++; if (stall_cnt !== 32'd7) begin n_err++; $display("FAIL perf_accept: got %0d want 7", stall_cnt); end
    icon_resp.valid = 1'b1;
    icon_resp.addr = {2'd3, 4'd9};
    icon_resp.data = 16'h005A;
    @(negedge clk);
    icon_resp = '0;
    n_cmp++; if (stall_cnt !== 32'd8) begin n_err++; $display("FAIL perf_fwait: got %0d want 8", stall_cnt); end
    k = 0;
    while (!alpu.op0_valid && k < 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (alpu.op0_valid !== 1'b1) begin
      n_err++; $display("FAIL perf_present: got valid %b want 1", alpu.op0_valid);
    end else begin
      e = sb.pop_front();
      if (alpu.op0_data !== e.d0 || alpu.op1_data !== e.d1) begin n_err++; $display("FAIL perf_data: got %h/%h want %h/%h", alpu.op0_data, alpu.op1_data, e.d0, e.d1); end
    end
    alpu_accept = 1'b1;
    @(negedge clk);
    alpu_accept = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    icon_req_rx = '0;
    icon_resp = '0;
    opd_ready = 1'b0;
    alpu_accept = 1'b0;
    lc_rd_data = '0;
    for (int i = 0; i < 16; i++) cache[i] = 16'h1000 + 16'(i);
    cache[3] = 16'h00AA;

    test_reset();
    test_imm();
    test_local();
    test_foreign();
    test_fifo_full();
    test_reset_fwait();
`ifdef EU_OPCOLLECT_PERF_EN
    test_perf();
`endif
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
